// File: rtl/pulse_train_gen.sv
// Pulse train generator: on start, emits N pulses of H high cycles separated by L low cycles.
// Config is captured at the accepted start; abort returns to idle at once without done.
module pulse_train_gen #(
   parameter int CNT_W    = 16,
   parameter int NUM_W    = 8,
   parameter int DEF_HIGH = 100
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] cfg_high,
   input  logic [CNT_W-1:0] cfg_low,
   input  logic [NUM_W-1:0] cfg_num,
   output logic             signal_out,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

   localparam logic [CNT_W-1:0] DEF_H = CNT_W'(DEF_HIGH);
   localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);
   localparam logic [NUM_W-1:0] ONE_N = NUM_W'(1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [CNT_W-1:0] high_len, high_len_nxt;
   logic [CNT_W-1:0] low_len, low_len_nxt;
   logic [NUM_W-1:0] left, left_nxt;
   logic             sig_nxt, busy_nxt, done_nxt;
   logic [CNT_W-1:0] start_high, start_low;

   // Zero-valued lengths are resolved once at start so the counters never see 0.
   assign start_high = (cfg_high == '0) ? DEF_H : cfg_high;
   assign start_low  = (cfg_low  == '0) ? ONE_C : cfg_low;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         high_len   <= '0;
         low_len    <= '0;
         left       <= '0;
         signal_out <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         high_len   <= high_len_nxt;
         low_len    <= low_len_nxt;
         left       <= left_nxt;
         signal_out <= sig_nxt;
         busy       <= busy_nxt;
         done       <= done_nxt;
      end
   end

   // cnt holds the cycles remaining after the current one; left counts pulses not yet finished.
   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      high_len_nxt = high_len;
      low_len_nxt  = low_len;
      left_nxt     = left;
      sig_nxt      = signal_out;
      busy_nxt     = busy;
      done_nxt     = 1'b0;
      if (abort) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
         left_nxt  = '0;
         sig_nxt   = 1'b0;
         busy_nxt  = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               sig_nxt  = 1'b0;
               busy_nxt = 1'b0;
               if (start) begin
                  high_len_nxt = start_high;
                  low_len_nxt  = start_low;
                  if (cfg_num != '0) begin
                     state_nxt = HIGH;
                     cnt_nxt   = start_high - ONE_C;
                     left_nxt  = cfg_num;
                     sig_nxt   = 1'b1;
                     busy_nxt  = 1'b1;
                  end else begin
                     done_nxt = 1'b1;
                  end
               end
            end
            HIGH: begin
               if (cnt != '0) begin
                  cnt_nxt = cnt - ONE_C;
               end else if (left > ONE_N) begin
                  state_nxt = LOW;
                  cnt_nxt   = low_len - ONE_C;
                  left_nxt  = left - ONE_N;
                  sig_nxt   = 1'b0;
               end else begin
                  state_nxt = IDLE;
                  left_nxt  = '0;
                  sig_nxt   = 1'b0;
                  busy_nxt  = 1'b0;
                  done_nxt  = 1'b1;
               end
            end
            LOW: begin
               if (cnt != '0) begin
                  cnt_nxt = cnt - ONE_C;
               end else begin
                  state_nxt = HIGH;
                  cnt_nxt   = high_len - ONE_C;
                  sig_nxt   = 1'b1;
               end
            end
            default: begin
               state_nxt = IDLE;
               sig_nxt   = 1'b0;
               busy_nxt  = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Bench for pulse_train_gen: directed trains, expected per-train records queued at launch
// and checked by a monitor when done pulses; includes a behavioural 1 us width detector.
module tb_pulse_train_gen;

   logic        clk = 1'b0;
   logic        rst_n, start, abort;
   logic [15:0] cfg_high, cfg_low;
   logic [7:0]  cfg_num;
   logic        signal_out, busy, done;

   pulse_train_gen dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .cfg_high(cfg_high), .cfg_low(cfg_low), .cfg_num(cfg_num),
      .signal_out(signal_out), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Record: {done_cycle, high_cycles, busy_cycles, last 64 signal_out bits while busy}
   logic [159:0] exp_q[$];
   int n_cmp = 0;
   int n_bad = 0;
   int det_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: accumulates each train and compares against the queued record on done.
   initial begin : monitor
      int hi_acc, bz_acc, run;
      logic [63:0]  pat_acc;
      logic         prev_busy;
      logic [159:0] e;
      hi_acc = 0; bz_acc = 0; run = 0; pat_acc = '0; prev_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            hi_acc = 0; bz_acc = 0; run = 0; pat_acc = '0; prev_busy = 1'b0;
         end else begin
            if (signal_out) run++;
            else begin
               if (run == 100) det_cnt++;
               run = 0;
            end
            if (busy) begin
               bz_acc++;
               if (signal_out) hi_acc++;
               pat_acc = {pat_acc[62:0], signal_out};
            end
            if (done) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
               end else begin
                  e = exp_q.pop_front();
                  check("done_cycle", 64'(cyc), 64'(e[159:128]));
                  check("high_cycles", 64'(hi_acc), 64'(e[127:96]));
                  check("busy_cycles", 64'(bz_acc), 64'(e[95:64]));
                  check("pattern", pat_acc, e[63:0]);
               end
               hi_acc = 0; bz_acc = 0; pat_acc = '0;
            end else if (prev_busy && !busy) begin
               hi_acc = 0; bz_acc = 0; pat_acc = '0;
            end
            prev_busy = busy;
         end
      end
   end

   task automatic launch(input logic [15:0] h, input logic [15:0] l, input logic [7:0] n,
                         input int off, input int hi, input int bz, input logic [63:0] pat);
      cfg_high = h;
      cfg_low  = l;
      cfg_num  = n;
      start    = 1'b1;
      exp_q.push_back({32'(cyc + off), 32'(hi), 32'(bz), pat});
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic summary();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
   endtask

   initial begin : watchdog
      #200000;
      n_cmp++;
      n_bad++;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      summary();
      $finish;
   end

   initial begin : driver
      int t, d0;
      rst_n = 1'b0; start = 1'b0; abort = 1'b0;
      cfg_high = '0; cfg_low = '0; cfg_num = '0;
      repeat (3) @(negedge clk);
      check("rst_signal_out", 64'(signal_out), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      rst_n = 1'b1;
      @(negedge clk);

      // Default high time, single pulse
      t = cyc;
      launch(16'd0, 16'd5, 8'd1, 101, 100, 100, '1);
      check("t1_out_at_T1", 64'(signal_out), 64'(1));
      check("t1_busy_at_T1", 64'(busy), 64'(1));
      wait_until(t + 103);

      // Three pulses with gaps
      t = cyc;
      launch(16'd3, 16'd2, 8'd3, 14, 9, 13, 64'b1110011100111);
      wait_until(t + 16);

      // Zero pulse count: done only
      t = cyc;
      launch(16'd7, 16'd7, 8'd0, 1, 0, 0, 64'd0);
      wait_until(t + 3);

      // Zero low time behaves as one cycle
      t = cyc;
      launch(16'd2, 16'd0, 8'd2, 6, 4, 5, 64'b11011);
      wait_until(t + 8);

      // Maximum pulse count with minimum lengths
      t = cyc;
      launch(16'd1, 16'd1, 8'd255, 510, 255, 509, 64'h5555_5555_5555_5555);
      wait_until(t + 512);

      // Stray start and cfg change mid-train; start in the done cycle is accepted
      t = cyc;
      launch(16'd4, 16'd3, 8'd2, 12, 8, 11, 64'b11110001111);
      wait_until(t + 4);
      cfg_high = 16'd9; cfg_low = 16'd1; cfg_num = 8'd7;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_until(t + 12);
      launch(16'd2, 16'd1, 8'd2, 6, 4, 5, 64'b11011);
      check("t4_relaunch_busy", 64'(busy), 64'(1));
      check("t4_relaunch_out", 64'(signal_out), 64'(1));
      wait_until(t + 20);

      // Abort during a high phase
      t = cyc;
      cfg_high = 16'd10; cfg_low = 16'd1; cfg_num = 8'd4;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_until(t + 6);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_out", 64'(signal_out), 64'(0));
      check("abort_busy", 64'(busy), 64'(0));
      check("abort_done", 64'(done), 64'(0));
      wait_until(t + 60);

      // Abort wins over start with zero pulse count
      cfg_num = 8'd0;
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      check("abort_start_done", 64'(done), 64'(0));
      check("abort_start_busy", 64'(busy), 64'(0));
      repeat (3) @(negedge clk);

      // Reset mid-train clears outputs immediately
      t = cyc;
      cfg_high = 16'd10; cfg_low = 16'd1; cfg_num = 8'd4;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_until(t + 5);
      check("pre_reset_busy", 64'(busy), 64'(1));
      rst_n = 1'b0;
      #1;
      check("mid_rst_out", 64'(signal_out), 64'(0));
      check("mid_rst_busy", 64'(busy), 64'(0));
      check("mid_rst_done", 64'(done), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Loopback into the 1 us detector
      d0 = det_cnt;
      t = cyc;
      launch(16'd0, 16'd20, 8'd5, 581, 500, 580, '1);
      wait_until(t + 583);
      check("detect_default", 64'(det_cnt - d0), 64'(5));
      d0 = det_cnt;
      t = cyc;
      launch(16'd99, 16'd20, 8'd5, 576, 495, 575, '1);
      wait_until(t + 578);
      check("detect_short", 64'(det_cnt - d0), 64'(0));

      check("queue_empty", 64'(exp_q.size()), 64'(0));
      summary();
      $finish;
   end

endmodule
